// File: rtl/counter_seq_ctrl.sv
// Command-driven sequencer for a WIDTH-bit counter: accepts one (mode, length)
// command over valid/ready, steps the count that many un-held cycles, then pulses done.
module counter_seq_ctrl #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_mode,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             hold,
  output logic [WIDTH-1:0] Cout,
  output logic             count_valid,
  output logic [1:0]       mode_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_EVEN = 2'd2;
  localparam logic [1:0] MODE_ODD  = 2'd3;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cout_q, cout_d;
  logic [1:0]       mode_q, mode_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] start_val, next_val;
  logic             accept, step, last_step;

  assign accept    = cmd_valid && (state_q == S_IDLE);
  assign step      = (state_q == S_RUN) && !hold;
  assign last_step = step && (rem_q == '0);

  always_comb begin
    unique case (cmd_mode)
      MODE_DOWN: start_val = '1;
      MODE_ODD:  start_val = WIDTH'(1);
      default:   start_val = '0;
    endcase
  end

  // Plain modulo-2^WIDTH arithmetic gives the required wraps (15->0, 0->15, 14->0, 15->1).
  always_comb begin
    unique case (mode_q)
      MODE_UP:   next_val = cout_q + WIDTH'(1);
      MODE_DOWN: next_val = cout_q - WIDTH'(1);
      MODE_EVEN: next_val = cout_q + WIDTH'(2);
      default:   next_val = cout_q + WIDTH'(2);
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (cmd_len == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_step) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode, from registered state only
  always_comb begin
    cmd_ready   = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    count_valid = (state_q == S_RUN);
    done        = (state_q == S_DONE);
    Cout        = cout_q;
    mode_out    = mode_q;
  end

  always_comb begin
    cout_d = cout_q;
    mode_d = mode_q;
    rem_d  = rem_q;
    if (accept) begin
      mode_d = cmd_mode;
      cout_d = start_val;
      rem_d  = (cmd_len == '0) ? '0 : cmd_len - LEN_W'(1);
    end else if (step && !last_step) begin
      cout_d = next_val;
      rem_d  = rem_q - LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      cout_q <= '0;
      mode_q <= '0;
      rem_q  <= '0;
    end else begin
      cout_q <= cout_d;
      mode_q <= mode_d;
      rem_q  <= rem_d;
    end
  end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Scoreboard bench for counter_seq_ctrl: stimulus pushes hand-computed expected
// steps/done records, a negedge monitor pops and compares them.
module tb_counter_seq_ctrl;

  logic       clk = 1'b0;
  logic       clear;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_mode;
  logic [7:0] cmd_len;
  logic       hold;
  logic [3:0] Cout;
  logic       count_valid;
  logic [1:0] mode_out;
  logic       busy;
  logic       done;

  counter_seq_ctrl #(.WIDTH(4), .LEN_W(8)) dut (
    .clk         (clk),
    .clear       (clear),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_mode    (cmd_mode),
    .cmd_len     (cmd_len),
    .hold        (hold),
    .Cout        (Cout),
    .count_valid (count_valid),
    .mode_out    (mode_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] c;
    logic [1:0] m;
  } done_t;

  int         n_vec  = 0;
  int         n_miss = 0;
  logic [3:0] step_q[$];
  done_t      done_q[$];
  logic [3:0] mon_exp;
  done_t      mon_done;

  int v_up5[5]    = '{0, 1, 2, 3, 4};
  int v_odd10[10] = '{1, 3, 5, 7, 9, 11, 13, 15, 1, 3};
  int v_even9[9]  = '{0, 2, 4, 6, 8, 10, 12, 14, 0};
  int v_dnh[5]    = '{15, 15, 15, 14, 13};
  int v_dn17[17]  = '{15, 14, 13, 12, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 1, 0, 15};
  int v_up17[17]  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 0};
  int v_start[4]  = '{0, 15, 0, 1};

  // Monitor: one pop per live step and per done pulse
  always @(negedge clk) begin
    if (count_valid === 1'b1) begin
      n_vec++;
      if (step_q.size() == 0) begin
        n_miss++;
        $display("FAIL step: unexpected count_valid, Cout=%0d, expected no step", Cout);
      end else begin
        mon_exp = step_q.pop_front();
        if (Cout !== mon_exp) begin
          n_miss++;
          $display("FAIL step: Cout=%0d, expected %0d", Cout, mon_exp);
        end else begin
          $display("step  mode=%0d Cout=%0d ok", mode_out, Cout);
        end
      end
    end
    if (done === 1'b1) begin
      n_vec++;
      if (done_q.size() == 0) begin
        n_miss++;
        $display("FAIL done: unexpected done pulse, Cout=%0d mode=%0d", Cout, mode_out);
      end else begin
        mon_done = done_q.pop_front();
        if (Cout !== mon_done.c || mode_out !== mon_done.m) begin
          n_miss++;
          $display("FAIL done: Cout=%0d mode=%0d, expected Cout=%0d mode=%0d",
                   Cout, mode_out, mon_done.c, mon_done.m);
        end else begin
          $display("done  mode=%0d Cout=%0d ok", mode_out, Cout);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic push_done(input int c, input int m);
    done_t d;
    d.c = 4'(c);
    d.m = 2'(m);
    done_q.push_back(d);
  endtask

  task automatic issue(input logic [1:0] m, input logic [7:0] len);
    int t;
    t = 0;
    while (cmd_ready !== 1'b1 && t < 200) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (cmd_ready !== 1'b1) begin
      n_vec++;
      n_miss++;
      $display("FAIL issue_timeout: cmd_ready=%0d, expected 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_mode  = m;
    cmd_len   = len;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Issue a command, hold for the first `holds` RUN cycles, check done latency and ready return
  task automatic run_cmd(input logic [1:0] m, input logic [7:0] len, input int holds);
    int cyc;
    issue(m, len);
    hold = (holds > 0);
    cyc  = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (cyc == holds + 1) hold = 1'b0;
    end while (done !== 1'b1 && cyc < 300);
    hold = 1'b0;
    chk("done_latency", 32'(cyc), 32'(int'(len) + holds + 1));
    @(negedge clk);
    chk("ready_after_done", 32'(cmd_ready), 32'd1);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("idle_reached", 32'(busy), 32'd0);
  endtask

  initial begin
    clear     = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode  = 2'd0;
    cmd_len   = 8'd0;
    hold      = 1'b0;
    #2 clear = 1'b0;
    #2;
    chk("rst_Cout", 32'(Cout), 32'd0);
    chk("rst_mode_out", 32'(mode_out), 32'd0);
    chk("rst_count_valid", 32'(count_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    clear = 1'b1;

    foreach (v_up5[i]) step_q.push_back(4'(v_up5[i]));
    push_done(4, 0);
    run_cmd(2'd0, 8'd5, 0);

    foreach (v_odd10[i]) step_q.push_back(4'(v_odd10[i]));
    push_done(3, 3);
    run_cmd(2'd3, 8'd10, 0);

    foreach (v_even9[i]) step_q.push_back(4'(v_even9[i]));
    push_done(0, 2);
    run_cmd(2'd2, 8'd9, 0);

    foreach (v_dnh[i]) step_q.push_back(4'(v_dnh[i]));
    push_done(13, 1);
    run_cmd(2'd1, 8'd3, 2);

    foreach (v_dn17[i]) step_q.push_back(4'(v_dn17[i]));
    push_done(15, 1);
    run_cmd(2'd1, 8'd17, 0);

    foreach (v_up17[i]) step_q.push_back(4'(v_up17[i]));
    push_done(0, 0);
    run_cmd(2'd0, 8'd17, 0);

    for (int m = 0; m < 4; m++) begin
      push_done(v_start[m], m);
      run_cmd(2'(m), 8'd0, 0);
      chk("len0_Cout_start", 32'(Cout), 32'(v_start[m]));
    end

    // Second command held on cmd_valid during RUN must wait for IDLE
    for (int i = 0; i < 4; i++) step_q.push_back(4'(i));
    push_done(3, 0);
    step_q.push_back(4'd1);
    step_q.push_back(4'd3);
    push_done(3, 3);
    issue(2'd0, 8'd4);
    cmd_valid = 1'b1;
    cmd_mode  = 2'd3;
    cmd_len   = 8'd2;
    for (int t = 0; t < 200 && cmd_ready !== 1'b1; t++) begin
      @(negedge clk);
      if (count_valid === 1'b1) chk("busy_mode_hold", 32'(mode_out), 32'd0);
    end
    chk("second_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("second_cmd_mode", 32'(mode_out), 32'd3);
    wait_idle();

    // Asynchronous clear between clock edges mid-RUN
    step_q.push_back(4'd15);
    step_q.push_back(4'd14);
    step_q.push_back(4'd13);
    issue(2'd1, 8'd10);
    repeat (3) @(negedge clk);
    #2 clear = 1'b0;
    #1;
    chk("clr_Cout", 32'(Cout), 32'd0);
    chk("clr_mode_out", 32'(mode_out), 32'd0);
    chk("clr_count_valid", 32'(count_valid), 32'd0);
    chk("clr_done", 32'(done), 32'd0);
    chk("clr_busy", 32'(busy), 32'd0);
    chk("clr_cmd_ready", 32'(cmd_ready), 32'd1);
    repeat (2) @(negedge clk);
    #2 clear = 1'b1;
    @(negedge clk);

    step_q.push_back(4'd0);
    step_q.push_back(4'd1);
    push_done(1, 0);
    run_cmd(2'd0, 8'd2, 0);

    repeat (3) @(negedge clk);
    chk("steps_left", 32'(step_q.size()), 32'd0);
    chk("dones_left", 32'(done_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Command-driven sequencer for the team's 4-bit counter datapath, with up, down, even and odd count modes.
- A requester issues one command through a valid/ready handshake: a mode and a step count.
- The block loads the mode's start value, steps the count for exactly that many un-held cycles, then pulses `done`.
- It sits between the control logic and the display/consumer of `Cout`. It replaces free-running per-mode counters with one scheduled datapath.

## Interface
Parameters:
- `WIDTH`, 4, counter width. Must be ≥ 2.
- `LEN_W`, 8, width of the step-count field.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `clear`  in  1  asynchronous, active-low reset. Forces the reset state immediately, independent of `clk`.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command. High only in IDLE.
- `cmd_mode`  in  2  mode: 0 up, 1 down, 2 even, 3 odd.
- `cmd_len`  in  LEN_W  number of count steps to produce.
- `hold`  in  1  freezes counting while high. Ignored outside RUN.
- `Cout`  out  WIDTH  current count value.
- `count_valid`  out  1  `Cout` is a live step of the running command.
- `mode_out`  out  2  mode of the current or last command.
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse when a command completes.

## Operation
States: IDLE, RUN, DONE.

Reset (`clear`=0, asynchronous):
- State goes to IDLE.
- Outputs: `Cout`=0, `mode_out`=0, `count_valid`=0, `done`=0, `busy`=0, `cmd_ready`=1.
- Internal remaining-count register = 0.

Handshake:
- A command is accepted on a rising edge where `cmd_valid`=1 and `cmd_ready`=1.
- `cmd_mode` and `cmd_len` are sampled on that edge.
- `cmd_valid` while `busy`=1 is ignored: no queuing, no effect.

On accept:
- `mode_out` ← `cmd_mode`.
- `Cout` ← start value: up 0, down 2^WIDTH−1, even 0, odd 1.
- If `cmd_len`=0: go to DONE. `Cout` still loads the start value, but `count_valid` never asserts.
- Else: remaining ← `cmd_len`−1 and go to RUN.

RUN:
- `count_valid`=1 every RUN cycle, including held cycles.
- A step is a RUN cycle with `hold`=0.
- On each rising edge in RUN with `hold`=0:
  - If remaining=0: go to DONE; `Cout` holds its value.
  - Else: `Cout` ← next(`Cout`) and remaining decrements.
- On each rising edge in RUN with `hold`=1: `Cout` and remaining hold.
- Exactly `cmd_len` steps occur. Step k (k from 0) presents the k-th element of the mode sequence.

Next-value rules (all modulo 2^WIDTH, with wrap):
- up: +1; 15→0.
- down: −1; 0→15.
- even: +2; 14→0.
- odd: +2; 15→1.

Even and odd modes cannot reach a wrong-parity value, because the start value is forced on accept.

DONE:
- Lasts exactly one cycle, then IDLE.
- `done`=1, `count_valid`=0, `busy`=1, `Cout` holds the last stepped value.

IDLE:
- `Cout` and `mode_out` hold their last values.
- `count_valid`=0.

Reset mid-command: aborts immediately to the reset state, with no `done` pulse.

## Timing
- All outputs are registered or decoded from registered state only. No combinational path from inputs to outputs, including `cmd_ready`.
- With `hold` low throughout, for a command accepted at edge E0:
  - `count_valid` is high for `cmd_len` cycles starting the cycle after E0.
  - `done` is high in cycle `cmd_len`+1 after E0.
  - `cmd_ready` returns high in cycle `cmd_len`+2.
  - Minimum command-to-command spacing is `cmd_len`+2 cycles.
- Each held cycle extends the RUN phase by one cycle.
- `cmd_len`=0: `done` is high in the cycle after E0; `cmd_ready` returns two cycles after E0.
- `hold` is sampled on the same edge as the step decision. It does not affect the accept edge or DONE.

## Test plan
- Up mode, `cmd_len`=5, `hold`=0 → `Cout` = 0,1,2,3,4 with `count_valid` high for 5 cycles. Next cycle: `done`=1, `Cout`=4. Then `cmd_ready`=1.
- Odd mode, `cmd_len`=10 → 1,3,5,7,9,11,13,15,1,3 (wrap 15→1). Even mode, `cmd_len`=9 → 0,2,…,14,0.
- Down mode, `cmd_len`=3, `hold` high for 2 cycles after the first step → `Cout` = 15,15,15,14,13 with `count_valid` high for 5 cycles. Then `done`.
- `cmd_len`=0 in any mode → `count_valid` never high; `done` pulses one cycle after accept; `Cout` = mode start value.
- `cmd_valid` held high with a different mode during RUN → no change to `Cout` or `mode_out`. The second command is accepted only once the block is back in IDLE.
- `clear` low mid-RUN, asserted between clock edges → all outputs take reset values immediately with no `done`. After release, a new up command, `cmd_len`=2 → 0,1.
